flag_unit: RTL and testbench

FLAG_UNIT -- requirements
Module: flag_unit

---
 rtl/flag_unit_pkg.sv | 65 ++++++
 rtl/flag_unit_if.sv | 24 ++
 rtl/flag_calc.sv | 21 ++
 rtl/flag_unit.sv | 50 +++++
 tb/tb_flag_unit.sv | 100 ++++++++++
 5 files changed

// File: rtl/flag_unit_pkg.sv
// Shared opcode encoding, flag bit positions, flag write masks and branch condition decode.
package flag_unit_pkg;

  localparam int unsigned OP_W     = 4;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned FLAG_W   = 3;
  localparam int unsigned Z_IDX    = 2;
  localparam int unsigned V_IDX    = 1;
  localparam int unsigned N_IDX    = 0;

  typedef enum logic [OP_W-1:0] {
    OP_ADD    = 4'b0000,
    OP_SUB    = 4'b0001,
    OP_XOR    = 4'b0010,
    OP_RED    = 4'b0011,
    OP_SLL    = 4'b0100,
    OP_SRA    = 4'b0101,
    OP_ROR    = 4'b0110,
    OP_PADDSB = 4'b0111,
    OP_LW     = 4'b1000,
    OP_SW     = 4'b1001,
    OP_LLB    = 4'b1010,
    OP_LHB    = 4'b1011,
    OP_B      = 4'b1100,
    OP_BR     = 4'b1101,
    OP_PCS    = 4'b1110,
    OP_HLT    = 4'b1111
  } op_e;

  // Which of {Z,V,N} an opcode is allowed to overwrite on commit.
  function automatic logic [FLAG_W-1:0] flag_wmask(input logic [OP_W-1:0] op);
    logic [FLAG_W-1:0] m;
    m = '0;
    case (op)
      OP_ADD, OP_SUB: begin
        m[Z_IDX] = 1'b1;
        m[V_IDX] = 1'b1;
        m[N_IDX] = 1'b1;
      end
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: m[Z_IDX] = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

  // Branch condition code evaluated against a {Z,V,N} flag vector.
  function automatic logic cond_met(input logic [2:0] ccc, input logic [FLAG_W-1:0] f);
    logic z, v, n, t;
    z = f[Z_IDX];
    v = f[V_IDX];
    n = f[N_IDX];
    case (ccc)
      3'b000:  t = ~z;
      3'b001:  t = z;
      3'b010:  t = ~z & ~n;
      3'b011:  t = n;
      3'b100:  t = z | ~n;
      3'b101:  t = n | z;
      3'b110:  t = v;
      default: t = 1'b1;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/flag_unit_if.sv
// EX-stage to flag unit bundle: instruction/pipeline controls in, flag state out.
interface flag_unit_if;
  import flag_unit_pkg::*;

  logic                ex_valid;
  logic [OP_W-1:0]     ex_op;
  logic [DATA_W-1:0]   ex_result;
  logic                ex_ovfl;
  logic                stall;
  logic                flush;
  logic [FLAG_W-1:0]   F;
  logic [FLAG_W-1:0]   F_byp;
  logic                halted;

  modport master (
    output ex_valid, ex_op, ex_result, ex_ovfl, stall, flush,
    input  F, F_byp, halted
  );

  modport slave (
    input  ex_valid, ex_op, ex_result, ex_ovfl, stall, flush,
    output F, F_byp, halted
  );
endinterface

// File: rtl/flag_calc.sv
// Combinational candidate flags {Z,V,N} and per-opcode write mask for the EX instruction.
module flag_calc
  import flag_unit_pkg::*;
(
  input  logic [OP_W-1:0]   op_i,
  input  logic [DATA_W-1:0] result_i,
  input  logic              ovfl_i,
  output logic [FLAG_W-1:0] flags_o,
  output logic [FLAG_W-1:0] wmask_o
);

  always_comb begin
    flags_o        = '0;
    flags_o[Z_IDX] = (result_i == DATA_W'(0));
    flags_o[V_IDX] = ovfl_i;
    flags_o[N_IDX] = result_i[DATA_W-1];
  end

  assign wmask_o = flag_wmask(op_i);

endmodule

// File: rtl/flag_unit.sv
// Flag register with RUN/HALTED control; merges partial flag writes and exposes a bypass view.
module flag_unit
  import flag_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  flag_unit_if.slave bus
);

  typedef enum logic {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [FLAG_W-1:0] f_q, f_d;
  logic [FLAG_W-1:0] calc_flags, calc_wmask;
  logic              commit;

  flag_calc u_calc (
    .op_i     (bus.ex_op),
    .result_i (bus.ex_result),
    .ovfl_i   (bus.ex_ovfl),
    .flags_o  (calc_flags),
    .wmask_o  (calc_wmask)
  );

  // Flush wins over stall; nothing commits once halted.
  always_comb begin
    commit  = bus.ex_valid & ~bus.stall & ~bus.flush & (state_q == ST_RUN);
    f_d     = f_q;
    state_d = state_q;
    if (commit) begin
      f_d = (f_q & ~calc_wmask) | (calc_flags & calc_wmask);
      if (bus.ex_op == OP_HLT) state_d = ST_HALTED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_q     <= '0;
      state_q <= ST_RUN;
    end else begin
      f_q     <= f_d;
      state_q <= state_d;
    end
  end

  assign bus.F      = f_q;
  assign bus.F_byp  = rst ? FLAG_W'(0) : f_d;
  assign bus.halted = (state_q == ST_HALTED);

endmodule

// File: tb/tb_flag_unit.sv
// Directed self-checking bench for flag_unit with hand-computed flag values.
module tb_flag_unit;
  import flag_unit_pkg::*;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  flag_unit_if bus ();

  flag_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present an instruction, check bypass before the edge, then check F/halted after it.
  task automatic cyc(input string tag, input logic v, input logic [3:0] op,
                     input logic [15:0] res, input logic ov, input logic st,
                     input logic fl, input logic [2:0] exp_byp,
                     input logic [2:0] exp_f, input logic exp_h);
    bus.ex_valid  = v;
    bus.ex_op     = op;
    bus.ex_result = res;
    bus.ex_ovfl   = ov;
    bus.stall     = st;
    bus.flush     = fl;
    #2;
    check_eq({tag, "_byp"}, 16'(bus.F_byp), 16'(exp_byp));
    @(posedge clk);
    #1;
    check_eq({tag, "_F"}, 16'(bus.F), 16'(exp_f));
    check_eq({tag, "_halted"}, 16'(bus.halted), 16'(exp_h));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.ex_valid = 1'b0; bus.ex_op = OP_ADD; bus.ex_result = '0;
    bus.ex_ovfl = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
    @(posedge clk); #1;

    // Reset overrides a simultaneous committing ADD
    cyc("rst_add", 1, OP_ADD, 16'h0000, 0, 0, 0, 3'b000, 3'b000, 0);
    rst = 1'b0;

    cyc("add_zero",   1, OP_ADD, 16'h0000, 0, 0, 0, 3'b100, 3'b100, 0);
    cyc("sub_neg_ov", 1, OP_SUB, 16'h8000, 1, 0, 0, 3'b011, 3'b011, 0);
    cyc("xor_nz",     1, OP_XOR, 16'h0001, 0, 0, 0, 3'b011, 3'b011, 0);
    cyc("xor_z",      1, OP_XOR, 16'h0000, 1, 0, 0, 3'b111, 3'b111, 0);
    cyc("add_pos",    1, OP_ADD, 16'h0001, 0, 0, 0, 3'b000, 3'b000, 0);

    // Held under stall for 3 cycles, commits once on release
    for (int i = 0; i < 3; i++)
      cyc("stall_hold", 1, OP_ADD, 16'h0000, 0, 1, 0, 3'b000, 3'b000, 0);
    cyc("stall_rel",  1, OP_ADD, 16'h0000, 0, 0, 0, 3'b100, 3'b100, 0);
    cyc("bubble_aft", 0, OP_ADD, 16'h0000, 0, 0, 0, 3'b100, 3'b100, 0);

    cyc("flush_stall", 1, OP_ADD, 16'h8000, 1, 1, 1, 3'b100, 3'b100, 0);
    cyc("flush_only",  1, OP_SUB, 16'h8000, 1, 0, 1, 3'b100, 3'b100, 0);
    cyc("bubble",      0, OP_ADD, 16'h8000, 1, 0, 0, 3'b100, 3'b100, 0);

    cyc("sub_set",  1, OP_SUB,    16'h8000, 1, 0, 0, 3'b011, 3'b011, 0);
    cyc("red",      1, OP_RED,    16'h0000, 0, 0, 0, 3'b011, 3'b011, 0);
    cyc("sll_z",    1, OP_SLL,    16'h0000, 0, 0, 0, 3'b111, 3'b111, 0);
    cyc("sra_nz",   1, OP_SRA,    16'h8005, 0, 0, 0, 3'b011, 3'b011, 0);
    cyc("ror_z",    1, OP_ROR,    16'h0000, 0, 0, 0, 3'b111, 3'b111, 0);
    cyc("paddsb",   1, OP_PADDSB, 16'h0001, 0, 0, 0, 3'b111, 3'b111, 0);
    cyc("lw",       1, OP_LW,     16'h0001, 0, 0, 0, 3'b111, 3'b111, 0);
    cyc("br",       1, OP_BR,     16'h8001, 0, 0, 0, 3'b111, 3'b111, 0);

    // Stalled HLT must not halt; then it commits
    cyc("hlt_stall", 1, OP_HLT, 16'h0001, 0, 1, 0, 3'b111, 3'b111, 0);
    cyc("hlt",       1, OP_HLT, 16'h0001, 0, 0, 0, 3'b111, 3'b111, 1);
    cyc("halt_add",  1, OP_ADD, 16'h0001, 0, 0, 0, 3'b111, 3'b111, 1);
    cyc("halt_sub",  1, OP_SUB, 16'h8000, 1, 0, 0, 3'b111, 3'b111, 1);

    rst = 1'b1;
    cyc("halt_rst",  1, OP_ADD, 16'h0001, 0, 0, 0, 3'b000, 3'b000, 0);
    rst = 1'b0;
    cyc("post_rst",  1, OP_ADD, 16'h0000, 0, 0, 0, 3'b100, 3'b100, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
